// File: rtl/hamming_secded_decoder.sv
// hamming_secded_decoder
//   Registered extended-Hamming SECDED decoder for 2^R-bit codewords.
//   Codeword bit 0 is the overall parity. Bit i (1..2^R-1) is Hamming
//   position i: parity bits sit at power-of-two positions and data bits
//   fill the remaining positions in ascending order.
//   The decoder corrects single errors (when correct_en is set when the
//   word is accepted) and flags double errors. The result is registered
//   one cycle after acceptance. Two saturating counters track the
//   corrected and uncorrectable words.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_code         received codeword (2^R bits)
//   in_valid        in_code valid
//   in_ready        block can take in_code this cycle
//   correct_en      1 = correct single errors, 0 = detect only
//   out_data        decoded data (2^R - R - 1 bits)
//   out_valid       out_* valid
//   out_ready       consumer accepts out_*
//   out_corrected   single error found
//   out_uncorr      double error detected
//   out_syndrome    Hamming syndrome of the word
//   clr_cnt         synchronous clear of both counters (wins over increment)
//   cnt_corrected   saturating count of corrected words
//   cnt_uncorr      saturating count of uncorrectable words
module hamming_secded_decoder #(
  parameter int R     = 3,
  parameter int CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [(1<<R)-1:0]         in_code,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      correct_en,
  output logic [(1<<R)-R-2:0]       out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_corrected,
  output logic                      out_uncorr,
  output logic [R-1:0]              out_syndrome,
  input  logic                      clr_cnt,
  output logic [CNT_W-1:0]          cnt_corrected,
  output logic [CNT_W-1:0]          cnt_uncorr
);

  localparam int CW_W   = 1 << R;
  localparam int DATA_W = CW_W - R - 1;
  localparam logic [CW_W-1:0] ONE = CW_W'(1);

  // Positions i (1..CW_W-1) whose index has bit k set.
  function automatic logic [CW_W-1:0] syn_mask(input int k);
    logic [CW_W-1:0] m;
    m = '0;
    for (int i = 1; i < CW_W; i++) begin
      if (((i >> k) & 1) == 1) m = m | (ONE << i);
    end
    return m;
  endfunction

  // Codeword position holding data bit j (j-th non-power-of-two index >= 3).
  function automatic int data_pos(input int j);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int i = 3; i < CW_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (cnt == j) pos = i;
        cnt++;
      end
    end
    return pos;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  logic [R-1:0]        syn_p0;
  logic                par_p0;
  logic                corr_p0;
  logic                unc_p0;
  logic [CW_W-1:0]     fix_p0;
  logic [DATA_W-1:0]   dat_p0;
  logic                acc_p0;

  logic                vld_p1;
  logic [DATA_W-1:0]   dat_p1;
  logic [R-1:0]        syn_p1;
  logic                corr_p1;
  logic                unc_p1;
  logic [CNT_W-1:0]    cnt_corr;
  logic [CNT_W-1:0]    cnt_unc;

  // ---- stage p0: combinational decode of the incoming codeword ----
  for (genvar k = 0; k < R; k++) begin : g_syn
    localparam logic [CW_W-1:0] MASK = syn_mask(k);
    assign syn_p0[k] = ^(in_code & MASK);
  end

  assign par_p0  = ^in_code;
  // Odd overall parity means exactly one flipped bit (possibly bit 0 itself);
  // even parity with a nonzero syndrome means two flipped bits.
  assign corr_p0 = par_p0;
  assign unc_p0  = !par_p0 && (syn_p0 != '0);
  // Syndrome 0 with odd parity points at bit 0, which carries no data, so
  // flipping it is harmless and keeps the expression uniform.
  assign fix_p0  = (par_p0 && correct_en) ? (in_code ^ (ONE << syn_p0)) : in_code;

  for (genvar j = 0; j < DATA_W; j++) begin : g_dat
    localparam int POS = data_pos(j);
    assign dat_p0[j] = fix_p0[POS];
  end

  assign in_ready = !vld_p1 || out_ready;
  assign acc_p0   = in_valid && in_ready;

  // ---- stage p1: output register and counters ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      dat_p1   <= '0;
      syn_p1   <= '0;
      corr_p1  <= 1'b0;
      unc_p1   <= 1'b0;
      cnt_corr <= '0;
      cnt_unc  <= '0;
    end else begin
      if (acc_p0) begin
        vld_p1  <= 1'b1;
        dat_p1  <= dat_p0;
        syn_p1  <= syn_p0;
        corr_p1 <= corr_p0;
        unc_p1  <= unc_p0;
      end else if (out_ready) begin
        vld_p1  <= 1'b0;
      end

      if (clr_cnt) begin
        cnt_corr <= '0;
        cnt_unc  <= '0;
      end else if (acc_p0) begin
        if (corr_p0) cnt_corr <= sat_inc(cnt_corr);
        if (unc_p0)  cnt_unc  <= sat_inc(cnt_unc);
      end
    end
  end

  assign out_valid     = vld_p1;
  assign out_data      = dat_p1;
  assign out_syndrome  = syn_p1;
  assign out_corrected = corr_p1;
  assign out_uncorr    = unc_p1;
  assign cnt_corrected = cnt_corr;
  assign cnt_uncorr    = cnt_unc;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
module tb_hamming_secded_decoder;

  localparam int R      = 3;
  localparam int CNT_W  = 2;
  localparam int CW_W   = 1 << R;
  localparam int DATA_W = CW_W - R - 1;
  localparam int MAXC   = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [R-1:0]      s;
    logic              corr;
    logic              unc;
  } res_t;

  typedef struct packed {
    logic [CW_W-1:0] code;
    logic            cen;
    res_t            exp;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [CW_W-1:0]   in_code;
  logic              in_valid;
  logic              in_ready;
  logic              correct_en;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_corrected;
  logic              out_uncorr;
  logic [R-1:0]      out_syndrome;
  logic              clr_cnt;
  logic [CNT_W-1:0]  cnt_corrected;
  logic [CNT_W-1:0]  cnt_uncorr;

  int total = 0;
  int bad   = 0;
  int m_cc  = 0;
  int m_cu  = 0;

  always #5 clk = ~clk;

  hamming_secded_decoder #(.R(R), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_code(in_code), .in_valid(in_valid), .in_ready(in_ready),
    .correct_en(correct_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_corrected(out_corrected), .out_uncorr(out_uncorr),
    .out_syndrome(out_syndrome),
    .clr_cnt(clr_cnt), .cnt_corrected(cnt_corrected), .cnt_uncorr(cnt_uncorr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference decode: syndrome is the XOR of the indices of all set bits,
  // overall parity is the XOR of all bits.
  function automatic res_t mdecode(input logic [CW_W-1:0] code, input logic cen);
    res_t r;
    logic [CW_W-1:0] c;
    int sx;
    int j;
    logic p;
    c  = code;
    sx = 0;
    for (int i = 1; i < CW_W; i++) if (c[i]) sx = sx ^ i;
    p = ^c;
    r.s    = R'(sx);
    r.corr = p;
    r.unc  = !p && (sx != 0);
    if (p && cen && sx != 0) c[sx] = ~c[sx];
    j = 0;
    r.d = '0;
    for (int i = 1; i < CW_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        r.d[j] = c[i];
        j++;
      end
    end
    return r;
  endfunction

  function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] c;
    int j;
    int sx;
    c  = '0;
    j  = 0;
    sx = 0;
    for (int i = 1; i < CW_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        c[i] = d[j];
        if (d[j]) sx = sx ^ i;
        j++;
      end
    end
    for (int k = 0; k < R; k++) c[1 << k] = sx[k];
    c[0] = ^c;
    return c;
  endfunction

  task automatic count(input res_t r);
    if (r.corr && m_cc < MAXC) m_cc++;
    if (r.unc && m_cu < MAXC) m_cu++;
  endtask

  task automatic chk_out(input string tag, input res_t e);
    chk({tag, "_vld"},  32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(e.d));
    chk({tag, "_syn"},  32'(out_syndrome), 32'(e.s));
    chk({tag, "_corr"}, 32'(out_corrected), 32'(e.corr));
    chk({tag, "_unc"},  32'(out_uncorr), 32'(e.unc));
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_cntc"}, 32'(cnt_corrected), 32'(m_cc));
    chk({tag, "_cntu"}, 32'(cnt_uncorr), 32'(m_cu));
  endtask

  vec_t tv[9];
  res_t seq_exp[4];
  logic [CW_W-1:0] seq_code[4];

  initial begin
    logic [CW_W-1:0] code;
    logic [DATA_W-1:0] d;
    int b1;
    int b2;
    logic m_full;
    logic exp_rdy;
    res_t m_slot;
    res_t r;

    tv[0] = '{code: 8'hAA, cen: 1'b1, exp: '{d: 4'hB, s: 3'd0, corr: 1'b0, unc: 1'b0}};
    tv[1] = '{code: 8'h8A, cen: 1'b1, exp: '{d: 4'hB, s: 3'd5, corr: 1'b1, unc: 1'b0}};
    tv[2] = '{code: 8'h8A, cen: 1'b0, exp: '{d: 4'h9, s: 3'd5, corr: 1'b1, unc: 1'b0}};
    tv[3] = '{code: 8'hAB, cen: 1'b1, exp: '{d: 4'hB, s: 3'd0, corr: 1'b1, unc: 1'b0}};
    tv[4] = '{code: 8'hCA, cen: 1'b1, exp: '{d: 4'hD, s: 3'd3, corr: 1'b0, unc: 1'b1}};
    tv[5] = '{code: 8'h2A, cen: 1'b1, exp: '{d: 4'hB, s: 3'd7, corr: 1'b1, unc: 1'b0}};
    tv[6] = '{code: 8'hA9, cen: 1'b1, exp: '{d: 4'hB, s: 3'd1, corr: 1'b0, unc: 1'b1}};
    tv[7] = '{code: 8'h00, cen: 1'b1, exp: '{d: 4'h0, s: 3'd0, corr: 1'b0, unc: 1'b0}};
    tv[8] = '{code: 8'hFF, cen: 1'b1, exp: '{d: 4'hF, s: 3'd0, corr: 1'b0, unc: 1'b0}};

    // Reset held with a valid word offered: nothing may be taken.
    rst = 1'b1; in_valid = 1'b1; in_code = 8'h8A; correct_en = 1'b1;
    out_ready = 1'b1; clr_cnt = 1'b0;
    tick();
    tick();
    chk("rst_vld",  32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_syn",  32'(out_syndrome), 32'd0);
    chk("rst_corr", 32'(out_corrected), 32'd0);
    chk("rst_unc",  32'(out_uncorr), 32'd0);
    chk_cnt("rst");
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_rdy", 32'(in_ready), 32'd1);
    tick();
    chk("idle_vld", 32'(out_valid), 32'd0);
    chk_cnt("idle");

    // Directed vectors, one word at a time.
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_code = tv[i].code; correct_en = tv[i].cen;
      tick();
      in_valid = 1'b0;
      count(tv[i].exp);
      chk_out($sformatf("vec%0d", i), tv[i].exp);
      chk_cnt($sformatf("vec%0d", i));
      tick();
      chk($sformatf("vec%0d_drain", i), 32'(out_valid), 32'd0);
    end

    // Back-to-back stream at full throughput.
    seq_code[0] = 8'hAA; seq_exp[0] = '{d: 4'hB, s: 3'd0, corr: 1'b0, unc: 1'b0};
    seq_code[1] = 8'hFF; seq_exp[1] = '{d: 4'hF, s: 3'd0, corr: 1'b0, unc: 1'b0};
    seq_code[2] = 8'h00; seq_exp[2] = '{d: 4'h0, s: 3'd0, corr: 1'b0, unc: 1'b0};
    seq_code[3] = 8'hCA; seq_exp[3] = '{d: 4'hD, s: 3'd3, corr: 1'b0, unc: 1'b1};
    correct_en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_code = seq_code[i];
      tick();
      count(seq_exp[i]);
      chk_out($sformatf("bb%0d", i), seq_exp[i]);
      chk($sformatf("bb%0d_rdy", i), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("bb_drain", 32'(out_valid), 32'd0);
    chk_cnt("bb");

    // Backpressure: word FF held for 3 stalled cycles while 00 waits.
    out_ready = 1'b0; in_valid = 1'b1; in_code = 8'hFF;
    tick();
    in_code = 8'h00;
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("bp%0d", i), '{d: 4'hF, s: 3'd0, corr: 1'b0, unc: 1'b0});
      chk($sformatf("bp%0d_rdy", i), 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_up", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk_out("bp_next", '{d: 4'h0, s: 3'd0, corr: 1'b0, unc: 1'b0});
    tick();
    chk("bp_drain", 32'(out_valid), 32'd0);
    chk_cnt("bp");

    // Counter saturation and clear-wins-over-increment.
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0; m_cc = 0; m_cu = 0;
    chk_cnt("clr");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_code = 8'h8A;
      tick();
      in_valid = 1'b0;
      m_cc = (i + 1 > MAXC) ? MAXC : i + 1;
      chk($sformatf("sat%0d_cntc", i), 32'(cnt_corrected), 32'(m_cc));
    end
    in_valid = 1'b1; in_code = 8'h8A; clr_cnt = 1'b1;
    tick();
    in_valid = 1'b0; clr_cnt = 1'b0; m_cc = 0;
    chk("clrwin_cntc", 32'(cnt_corrected), 32'd0);
    chk("clrwin_vld", 32'(out_valid), 32'd1);
    tick();

    // Reset discards a pending word.
    out_ready = 1'b0; in_valid = 1'b1; in_code = 8'hCA;
    tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; m_cc = 0; m_cu = 0;
    chk("midrst_vld", 32'(out_valid), 32'd0);
    chk("midrst_unc", 32'(out_uncorr), 32'd0);
    chk_cnt("midrst");

    // Randomized traffic against the reference model.
    m_full = 1'b0;
    m_slot = '0;
    for (int n = 0; n < 600; n++) begin
      chk("rnd_vld", 32'(out_valid), 32'(m_full));
      if (m_full) begin
        chk("rnd_data", 32'(out_data), 32'(m_slot.d));
        chk("rnd_syn",  32'(out_syndrome), 32'(m_slot.s));
        chk("rnd_corr", 32'(out_corrected), 32'(m_slot.corr));
        chk("rnd_unc",  32'(out_uncorr), 32'(m_slot.unc));
      end
      chk_cnt("rnd");

      d = DATA_W'($urandom);
      code = encode(d);
      b1 = $urandom_range(0, 2);
      if (b1 >= 1) begin
        b2 = $urandom_range(0, CW_W - 1);
        code[b2] = ~code[b2];
        if (b1 == 2) begin
          b2 = (b2 + $urandom_range(1, CW_W - 1)) % CW_W;
          code[b2] = ~code[b2];
        end
      end
      in_code    = code;
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      correct_en = 1'($urandom_range(0, 1));
      clr_cnt    = ($urandom_range(0, 19) == 0);
      #1;
      exp_rdy = !m_full || out_ready;
      chk("rnd_rdy", 32'(in_ready), 32'(exp_rdy));
      r = mdecode(code, correct_en);
      if (b1 <= 1 && correct_en) chk("rnd_model_sanity", 32'(r.d), 32'(d));
      if (in_valid && exp_rdy) begin
        m_slot = r;
        m_full = 1'b1;
        count(r);
      end else if (m_full && out_ready) begin
        m_full = 1'b0;
      end
      if (clr_cnt) begin
        m_cc = 0;
        m_cu = 0;
      end
      tick();
    end
    in_valid = 1'b0; clr_cnt = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
